// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_load_ctrl_pkg;

  localparam int unsigned ByteWidth = 8;
  localparam int unsigned ByteLanes = 4;
  localparam int unsigned BcntW     = $clog2(ByteLanes);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAssemble = 2'd1,
    StWrite    = 2'd2,
    StDone     = 2'd3
  } state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte stream in and instruction-memory write port out of the program loader.
interface imem_load_ctrl_if #(
  parameter int unsigned MP_WIDTH = 32
);
  import imem_load_ctrl_pkg::*;

  logic [ByteWidth-1:0] ibyte;
  logic                 ibyte_valid;
  logic                 obyte_ready;
  logic                 omem_we;
  logic [MP_WIDTH-1:0]  omem_waddr;
  logic [MP_WIDTH-1:0]  omem_wdata;

  modport slave (
    input  ibyte, ibyte_valid,
    output obyte_ready, omem_we, omem_waddr, omem_wdata
  );

  modport master (
    output ibyte, ibyte_valid,
    input  obyte_ready, omem_we, omem_waddr, omem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; flags the fourth byte.
module imem_word_packer
  import imem_load_ctrl_pkg::*;
(
  input  logic                           iclk,
  input  logic                           irst_n,
  input  logic                           iaccept,
  input  logic [ByteWidth-1:0]           ibyte,
  output logic [ByteLanes*ByteWidth-1:0] oword,
  output logic                           oword_valid
);

  logic [BcntW-1:0]               bcnt_q;
  logic [ByteLanes*ByteWidth-1:0] word_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      bcnt_q <= '0;
      word_q <= '0;
    end else if (iaccept) begin
      word_q[{bcnt_q, 3'b000} +: ByteWidth] <= ibyte;
      bcnt_q                                <= bcnt_q + BcntW'(1);
    end
  end

  // Word stays stable in the register through the following write cycle.
  assign oword       = word_q;
  assign oword_valid = iaccept & (bcnt_q == BcntW'(ByteLanes - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Program loader: streams bytes into instruction memory while holding the core
// and stalling fetch, so the memory has exactly one owner at a time.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int unsigned MP_WIDTH     = 32,
  parameter int unsigned MP_DEPTH     = 256,
  parameter bit          MP_BOOT_HOLD = 1'b0,
  localparam int unsigned LW          = $clog2(MP_DEPTH) + 1
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic                istart,
  input  logic [LW-1:0]       ilen,
  imem_load_ctrl_if.slave     bus,
  input  logic                ifetch_req,
  input  logic [MP_WIDTH-1:0] ifetch_addr,
  output logic [MP_WIDTH-1:0] omem_raddr,
  output logic                ofetch_stall,
  output logic                ocore_hold,
  output logic                obusy,
  output logic                odone,
  output logic                oerr
);

  state_e                         state_q, state_d;
  logic [LW-1:0]                  len_q, wcnt_q, wcnt_inc;
  logic                           done_q, err_q, hold_q;
  logic                           len_ok, start_ok, start_bad, byte_acc, word_valid;
  logic [ByteLanes*ByteWidth-1:0] word;

  assign len_ok    = (ilen != '0) && (32'(ilen) <= MP_DEPTH);
  assign start_ok  = istart & (state_q == StIdle) & len_ok;
  assign start_bad = istart & (state_q == StIdle) & ~len_ok;
  assign byte_acc  = bus.ibyte_valid & bus.obyte_ready;
  assign wcnt_inc  = wcnt_q + LW'(1);

  imem_word_packer u_packer (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .iaccept     (byte_acc),
    .ibyte       (bus.ibyte),
    .oword       (word),
    .oword_valid (word_valid)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start_ok) state_d = StAssemble;
      StAssemble: if (word_valid) state_d = StWrite;
      StWrite:    state_d = (wcnt_inc == len_q) ? StDone : StAssemble;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      len_q  <= '0;
      wcnt_q <= '0;
    end else if (start_ok) begin
      len_q  <= ilen;
      wcnt_q <= '0;
    end else if (state_q == StWrite) begin
      wcnt_q <= wcnt_inc;
    end
  end

  // Status levels persist across IDLE; a rejected start leaves done/hold alone.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= MP_BOOT_HOLD;
    end else begin
      if (start_ok) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        hold_q <= 1'b1;
      end else if (start_bad) begin
        err_q <= 1'b1;
      end
      if ((state_q == StWrite) && (state_d == StDone)) begin
        done_q <= 1'b1;
        hold_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.obyte_ready = (state_q == StAssemble);
    bus.omem_we     = (state_q == StWrite);
    bus.omem_waddr  = MP_WIDTH'({wcnt_q, 2'b00});
    bus.omem_wdata  = word;
    obusy           = (state_q == StAssemble) || (state_q == StWrite);
    odone           = done_q;
    oerr            = err_q;
    ocore_hold      = hold_q;
    omem_raddr      = ifetch_addr;
    ofetch_stall    = ifetch_req & (obusy | hold_q);
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: vector table of loads plus
// hand-written reset / mid-load start / fetch-stall sequences; writes are
// checked against a queue of expected {addr, data}.
module tb_imem_load_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 256;
  localparam int unsigned LW = 9;

  typedef struct packed {
    logic [LW-1:0]    len;
    logic [3:0][31:0] w;
    logic             err;
    logic             gap;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          istart = 1'b0;
  logic [LW-1:0] ilen = '0;
  logic          ifetch_req = 1'b0;
  logic [31:0]   ifetch_addr = '0;
  logic [31:0]   raddr;
  logic          stall, hold, busy, done, err;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  int          stall_cnt = 0;
  int          raddr_bad = 0;
  int          rdy_in_wr = 0;
  logic [31:0] last_waddr = '0;
  logic        done_exp = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  vec_t        vecs[7];

  imem_load_ctrl_if #(.MP_WIDTH(W)) bus ();

  imem_load_ctrl #(
    .MP_WIDTH     (W),
    .MP_DEPTH     (D),
    .MP_BOOT_HOLD (1'b0)
  ) dut (
    .iclk         (clk),
    .irst_n       (rst_n),
    .istart       (istart),
    .ilen         (ilen),
    .bus          (bus),
    .ifetch_req   (ifetch_req),
    .ifetch_addr  (ifetch_addr),
    .omem_raddr   (raddr),
    .ofetch_stall (stall),
    .ocore_hold   (hold),
    .obusy        (busy),
    .odone        (done),
    .oerr         (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Write monitor and scoreboard; samples on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) stall_cnt++;
      if (raddr !== ifetch_addr) raddr_bad++;
      if (bus.omem_we) begin
        wr_cnt++;
        last_waddr = bus.omem_waddr;
        if (bus.obyte_ready) rdy_in_wr++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual_addr=0x%08h actual_data=0x%08h required=no write",
                   bus.omem_waddr, bus.omem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.omem_waddr, mon_e.addr);
          chk("wr_data", bus.omem_wdata, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int len, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic e, input logic g);
    vec_t v;
    v.len  = LW'(len);
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    v.err  = e;
    v.gap  = g;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    return v.w[i % 4] + 32'(i / 4);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.ibyte       = b;
    bus.ibyte_valid = 1'b1;
    while (!bus.obyte_ready && n < 20) begin
      tick();
      n++;
    end
    chk("byte_ready", 32'(bus.obyte_ready), 32'd1);
    tick();
    bus.ibyte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes, input logic gap);
    for (int k = 0; k < nbytes; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap) tick();
    end
  endtask

  task automatic start_load(input int len);
    istart = 1'b1;
    ilen   = LW'(len);
    tick();
    istart = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          w0;
    logic [31:0] wd;
    w0 = wr_cnt;
    start_load(int'(v.len));
    if (v.err) begin
      chk($sformatf("v%0d_rej_err", idx), 32'(err), 32'd1);
      chk($sformatf("v%0d_rej_busy", idx), 32'(busy), 32'd0);
      tick();
      chk($sformatf("v%0d_rej_busy2", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d_rej_hold", idx), 32'(hold), 32'd0);
      chk($sformatf("v%0d_rej_done", idx), 32'(done), 32'(done_exp));
      chk($sformatf("v%0d_rej_writes", idx), 32'(wr_cnt - w0), 32'd0);
    end else begin
      chk($sformatf("v%0d_acc_busy", idx), 32'(busy), 32'd1);
      chk($sformatf("v%0d_acc_hold", idx), 32'(hold), 32'd1);
      chk($sformatf("v%0d_acc_err", idx), 32'(err), 32'd0);
      chk($sformatf("v%0d_acc_done", idx), 32'(done), 32'd0);
      for (int i = 0; i < int'(v.len); i++) begin
        wd = word_of(v, i);
        exp_q.push_back('{addr: 32'(i) << 2, data: wd});
        send_word(wd, 4, v.gap);
      end
      wait_done();
      chk($sformatf("v%0d_done_hold", idx), 32'(hold), 32'd0);
      chk($sformatf("v%0d_done_busy", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d_writes", idx), 32'(wr_cnt - w0), 32'(v.len));
      chk($sformatf("v%0d_last_addr", idx), last_waddr, (32'(v.len) - 32'd1) << 2);
      chk($sformatf("v%0d_queue", idx), 32'(exp_q.size()), 32'd0);
      done_exp = 1'b1;
      tick();
      chk($sformatf("v%0d_idle_done", idx), 32'(done), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"}, 32'(bus.omem_we), 32'd0);
    chk({tag, "_waddr"}, bus.omem_waddr, 32'd0);
    chk({tag, "_wdata"}, bus.omem_wdata, 32'd0);
    chk({tag, "_ready"}, 32'(bus.obyte_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
  endtask

  initial begin
    int w0;
    bus.ibyte       = '0;
    bus.ibyte_valid = 1'b0;

    vecs[0] = mk(2, 32'h00000013, 32'h00100093, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[1] = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[2] = mk(257, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vecs[3] = mk(1, 32'hdeadbeef, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[4] = mk(3, 32'h11223344, 32'ha5a5a5a5, 32'h0000ff00, 32'h0, 1'b0, 1'b1);
    vecs[5] = mk(256, 32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c, 1'b0, 1'b0);
    vecs[6] = mk(511, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    tick();
    tick();
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Fetch stalled from the cycle after start through WRITE (5 cycles at full rate).
    stall_cnt   = 0;
    raddr_bad   = 0;
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h8;
    tick();
    start_load(1);
    exp_q.push_back('{addr: 32'h0, data: 32'hcafef00d});
    send_word(32'hcafef00d, 4, 1'b0);
    wait_done();
    chk("fetch_done_stall", 32'(stall), 32'd0);
    tick();
    tick();
    chk("fetch_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("fetch_raddr", raddr, 32'h8);
    chk("fetch_raddr_bad", 32'(raddr_bad), 32'd0);
    ifetch_req = 1'b0;
    done_exp   = 1'b1;

    // Reset after six bytes of a 3-word load: only word 0 lands.
    w0 = wr_cnt;
    start_load(3);
    exp_q.push_back('{addr: 32'h0, data: 32'h76543210});
    send_word(32'h76543210, 4, 1'b0);
    send_word(32'hfedcba98, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd1);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    done_exp = 1'b0;
    run_vec(7, mk(1, 32'h0badc0de, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));

    // Start pulse during a load is ignored without error.
    w0 = wr_cnt;
    start_load(2);
    exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
    exp_q.push_back('{addr: 32'h4, data: 32'h88776655});
    send_word(32'h44332211, 2, 1'b0);
    istart = 1'b1;
    ilen   = LW'(5);
    tick();
    istart = 1'b0;
    chk("mid_start_err", 32'(err), 32'd0);
    chk("mid_start_busy", 32'(busy), 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    send_word(32'h88776655, 4, 1'b0);
    wait_done();
    chk("mid_start_writes", 32'(wr_cnt - w0), 32'd2);
    chk("mid_start_queue", 32'(exp_q.size()), 32'd0);
    tick();

    chk("ready_in_write", 32'(rdy_in_wr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
